aes_key_expand: RTL and testbench

//  AES-128 key schedule engine and round-key store. It sits upstream of the cipher/inverse-cipher round

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_expand.sv | 125 ++++++++++++
 tb/tb_aes_key_expand.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, the forward S-box, round constants and word helpers.
// Used by the key schedule and the cipher round datapaths.
package aes_pkg;

    typedef logic [127:0] round_key_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GEN
    } ke_state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
// Also instanced four-wide by the cipher SubBytes stage.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                       SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: streams RK0..RK10 one per cycle after start and keeps
// all eleven keys in a register file with a registered random-access read port.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    output logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_out,
    output logic             done,
    output logic             keys_ready,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);

    if (NR != 10 || KEY_W != 128) begin : g_bad_param
        $error("aes_key_expand supports only NR=10 and KEY_W=128");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ke_state_t        state, state_next;
    logic [3:0]       r;
    logic             accept;
    logic             emit;
    logic             last_gen;
    logic [3:0]       emit_idx;
    logic [KEY_W-1:0] emit_key;
    logic [KEY_W-1:0] next_key;
    logic [KEY_W-1:0] rf [0:NR];

    logic [31:0] sub_rot;
    logic [31:0] t_word;
    logic [31:0] n0, n1, n2, n3;
    logic [7:0]  rcon_byte;

    // The previous key is always the streamed output register, so one cone suffices.
    aes_sub_word u_sub_word (
        .word_in  (rot_word(rk_out[31:0])),
        .word_out (sub_rot)
    );

    always_comb begin
        rcon_byte = (r >= 4'd1 && r <= LAST_ROUND) ? RCON[r] : 8'h00;
        t_word    = sub_rot ^ {rcon_byte, 24'h0};
        n0        = rk_out[127:96] ^ t_word;
        n1        = rk_out[95:64]  ^ n0;
        n2        = rk_out[63:32]  ^ n1;
        n3        = rk_out[31:0]   ^ n2;
        next_key  = {n0, n1, n2, n3};
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        emit       = 1'b0;
        emit_idx   = r;
        emit_key   = next_key;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                emit       = 1'b1;
                emit_idx   = 4'd0;
                emit_key   = key_in;
                state_next = ST_GEN;
            end
            ST_GEN: begin
                emit = 1'b1;
                if (r == LAST_ROUND) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign last_gen = (state == ST_GEN) && (r == LAST_ROUND);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            r          <= 4'd0;
            busy       <= 1'b0;
            rk_valid   <= 1'b0;
            rk_idx     <= 4'd0;
            rk_out     <= '0;
            done       <= 1'b0;
            keys_ready <= 1'b0;
            rd_key     <= '0;
        end else begin
            state    <= state_next;
            busy     <= (state != ST_IDLE);
            rk_valid <= emit;
            done     <= last_gen;
            if (emit) begin
                rk_out <= emit_key;
                rk_idx <= emit_idx;
            end
            if (state == ST_LOAD)      r <= 4'd1;
            else if (last_gen)         r <= 4'd0;
            else if (state == ST_GEN)  r <= r + 4'd1;
            if (accept)                keys_ready <= 1'b0;
            else if (last_gen)         keys_ready <= 1'b1;
            rd_key <= (rd_idx <= LAST_ROUND) ? rf[rd_idx] : '0;
        end
    end

    // NOTE: the key store is deliberately not reset; keys_ready tells consumers when it is valid.
    always_ff @(posedge clk) begin
        if (emit) rf[emit_idx] <= emit_key;
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand; expected keys come from an independent
// GF(2^8) reference model plus hand-copied FIPS-197 constants.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         done;
    logic         keys_ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    aes_key_expand #(.NR(10), .KEY_W(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .done       (done),
        .keys_ready (keys_ready),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        logic [7:0] x;
        for (int k = 0; k < 254; k++) inv = gmul(inv, a);
        s = inv;
        x = inv;
        for (int k = 0; k < 4; k++) begin
            x = {x[6:0], x[7]};
            s = s ^ x;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_ref(input logic [127:0] p, input int r);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        for (int k = 2; k <= r; k++) rc = xtime(rc);
        t  = {sbox_ref(p[23:16]), sbox_ref(p[15:8]), sbox_ref(p[7:0]), sbox_ref(p[31:24])}
             ^ {rc, 24'h0};
        n0 = p[127:96] ^ t;
        n1 = p[95:64]  ^ n0;
        n2 = p[63:32]  ^ n1;
        n3 = p[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an expansion and checks every streamed key. inject_i >= 0 re-pulses start
    // with alt_key so that it is sampled at edge T+1+inject_i.
    task automatic run_key(input string name, input logic [127:0] key, input int inject_i,
                           input logic [127:0] alt_key,
                           output logic [127:0] got1, output logic [127:0] got10);
        logic [127:0] exp_key;
        key_in = key;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check({name, ":ready_clear"}, keys_ready, 0);
        check({name, ":busy_at_T"}, busy, 0);
        exp_key = key;
        got1    = '0;
        got10   = '0;
        for (int i = 0; i <= 10; i++) begin
            if (i == inject_i) begin
                start  = 1'b1;
                key_in = alt_key;
            end
            tick();
            start = 1'b0;
            if (i == 0) key_in = ~key;
            if (i > 0) exp_key = next_ref(exp_key, i);
            check($sformatf("%s:rk_valid[%0d]", name, i), rk_valid, 1);
            check($sformatf("%s:rk_idx[%0d]", name, i), rk_idx, 128'(i));
            check($sformatf("%s:rk_out[%0d]", name, i), rk_out, exp_key);
            check($sformatf("%s:busy[%0d]", name, i), busy, 1);
            check($sformatf("%s:done[%0d]", name, i), done, 128'(i == 10));
            if (i == 1)  got1  = rk_out;
            if (i == 10) got10 = rk_out;
        end
        check({name, ":keys_ready"}, keys_ready, 1);
    endtask

    initial begin
        logic [127:0] g1, g10;
        logic [127:0] ref_rk [0:10];
        int           done_seen;

        rst    = 1'b1;
        start  = 1'b0;
        key_in = KEY_A1;
        rd_idx = 4'd0;
        tick();
        tick();
        check("rst:busy", busy, 0);
        check("rst:rk_valid", rk_valid, 0);
        check("rst:rk_idx", rk_idx, 0);
        check("rst:rk_out", rk_out, 0);
        check("rst:done", done, 0);
        check("rst:keys_ready", keys_ready, 0);
        check("rst:rd_key", rd_key, 0);
        rst = 1'b0;
        tick();

        // FIPS-197 A.1 schedule
        run_key("a1", KEY_A1, -1, '0, g1, g10);
        check("a1:rk1_const", g1, 128'ha0fafe1788542cb123a339392a6c7605);
        check("a1:rk10_const", g10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reverse sweep of the key store, then out-of-range indices
        ref_rk[0] = KEY_A1;
        for (int i = 1; i <= 10; i++) ref_rk[i] = next_ref(ref_rk[i-1], i);
        for (int i = 10; i >= 0; i--) begin
            rd_idx = 4'(i);
            tick();
            check($sformatf("rd_key[%0d]", i), rd_key, ref_rk[i]);
        end
        rd_idx = 4'd11;
        tick();
        check("rd_key[11]", rd_key, 0);
        rd_idx = 4'd15;
        tick();
        check("rd_key[15]", rd_key, 0);
        check("idle:busy", busy, 0);
        check("idle:rk_valid", rk_valid, 0);

        // Start pulsed at T+4 with a different key must be ignored
        run_key("inj", KEY_A1, 3, KEY_ZERO, g1, g10);
        check("inj:rk10_const", g10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();
        check("inj:no_restart_valid", rk_valid, 0);
        check("inj:no_second_done", done, 0);
        check("inj:busy_T12", busy, 0);

        // Back-to-back: zero key accepted at T+12
        run_key("b2b_a1", KEY_A1, -1, '0, g1, g10);
        run_key("zero", KEY_ZERO, -1, '0, g1, g10);
        check("zero:rk1_const", g1, 128'h62636363626363636263636362636363);
        check("zero:rk10_const", g10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Reset mid-expansion, taking effect at T+7
        tick();
        key_in = KEY_A1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("mid:rk_idx_T6", rk_idx, 5);
        rst = 1'b1;
        tick();
        check("mid:busy", busy, 0);
        check("mid:rk_valid", rk_valid, 0);
        check("mid:keys_ready", keys_ready, 0);
        check("mid:done", done, 0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done || rk_valid) done_seen++;
        end
        check("mid:no_activity_after_rst", 128'(done_seen), 0);

        run_key("fresh", KEY_A1, -1, '0, g1, g10);
        check("fresh:rk10_const", g10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
